secded_stream_decoder: RTL and testbench
========================================

# secded_stream_decoder

Parametrised SECDED (extended Hamming) decoder on the AXI-stream datapath, successor to the fixed single-width syndrome decoder. Accepts one codeword per beat on `data_in`, computes syndrome and overall parity, corrects single-bit errors, flags double-bit errors, and emits the extracted data word on `data_out` through a 2-stage backpressure-aware pipeline. Per-error-class saturating counters support link-health monitoring.

## Interface
- `DATA_WIDTH`, 32: payload bits per beat.
- `PARITY_BITS`, derived: smallest r with 2^r ≥ DATA_WIDTH + r + 1 (6 for 32).
- `CODE_WIDTH`, derived: DATA_WIDTH + PARITY_BITS + 1 (39 for 32).
- `COUNTER_WIDTH`, 16: width of the error counters.

- `clock`  in  1  single block clock.
- `reset`  in  1  synchronous, active-low reset.
- `data_in`  axi_stream.slave  codeword in `data[CODE_WIDTH-1:0]`; `dest`, `user`, `tlast` accompany it.
- `data_out`  axi_stream.master  corrected word in `data[DATA_WIDTH-1:0]` (upper bits 0); `user[1:0]` = {uncorrectable, corrected}; `dest`, `tlast` forwarded.
- `correct_en`  in  1  1 = correct single errors; 0 = detect only (flags set, data uncorrected).
- `clear_counters`  in  1  synchronous clear of both counters.
- `corrected_count`  out  COUNTER_WIDTH  beats with a correctable error.
- `uncorrectable_count`  out  COUNTER_WIDTH  beats with a detected double error.

## Operation
- Codeword layout: bit 0 = overall parity; bits at power-of-two positions 1, 2, 4, … = Hamming parity; remaining positions, ascending, = data bits LSB first.
- Stage 1 (syndrome): syndrome s[PARITY_BITS-1:0] = XOR of positions whose index has bit k set; p = XOR of all CODE_WIDTH bits. Registers codeword, s, p, dest, tlast, `correct_en`.
- Stage 2 (correct/extract), classification:
  - s = 0, p = 0: clean; user = 2'b00.
  - s = 0, p = 1: overall-parity bit error; data intact; user = 2'b01.
  - s ≠ 0, p = 1, s ≤ CODE_WIDTH-1: single error at position s; flip it when `correct_en`=1; user = 2'b01.
  - s ≠ 0, p = 1, s > CODE_WIDTH-1: uncorrectable; user = 2'b10.
  - s ≠ 0, p = 0: double error; data passed uncorrected; user = 2'b10.
- Input `user` bits are not forwarded.
- Counters increment on the output handshake (`data_out.valid && data_out.ready`) by class; saturate at all-ones; `clear_counters` wins over a same-cycle increment (result 0).
- `correct_en` is sampled per beat at stage-1 capture; mid-stream changes affect only later beats.

## Timing
- Latency: 2 cycles from input handshake to `data_out.valid` with no backpressure; throughput 1 beat/cycle.
- Stage k loads when empty or when its content leaves this cycle. `data_in.ready` = !s1_valid || s1_leaving; it is combinational from `data_out.ready` (no skid buffer). At most 2 beats are held under full stall.
- `data_out.valid`, `data`, `user`, `dest`, `tlast` stay stable while valid && !ready.
- Reset (reset = 0 on a rising edge): both stage valids 0, counters 0, `data_out.valid` 0, `data_out.data`/`user` 0, `data_in.ready` 0 during reset, 1 on the first cycle after release. In-flight beats are discarded.

## Structure
- Package `secded_pkg`: functions `parity_bits(dw)` and `code_width(dw)`, `is_pow2(pos)`, data-position map function, `err_class_t` enum {CLEAN, CORRECTED, UNCORRECTABLE}.
- Sub-module `secded_syndrome_stage`: registered stage 1 (syndrome + parity + sideband), parametrised by DATA_WIDTH. Stage 2, the handshake, and the counters stay in the top.

## Test plan
- DATA_WIDTH=32, encode 0xDEADBEEF cleanly, 1 beat -> out 0xDEADBEEF, user 2'b00, valid exactly 2 cycles after input handshake, counters 0/0.
- Same codeword with position 5 flipped, `correct_en`=1 -> out 0xDEADBEEF, user 2'b01, corrected_count 1; repeat with `correct_en`=0 -> data has the bit-5 error, user 2'b01.
- Flip positions 3 and 10 -> user 2'b10, uncorrectable_count 1; flip bit 0 only -> data 0xDEADBEEF, user 2'b01.
- Stream 8 beats (dest 0..7, tlast on beat 7); hold `data_out.ready` low cycles 3–6 -> `data_in.ready` drops after 2 beats are held, output order/dest/tlast preserved, no loss or duplication.
- COUNTER_WIDTH=4, 20 single-error beats -> corrected_count saturates at 15; `clear_counters` asserted on the same cycle as a handshake -> 0.
- Assert reset with 2 beats in flight -> `data_out.valid` 0 next cycle, counters 0; a clean beat after release -> normal 2-cycle latency.

Source files
------------

// File: rtl/secded_pkg.sv
// Shared SECDED helpers: code geometry, position map and error classes.
// Imported by the syndrome stage and the stream decoder top.
package secded_pkg;

  typedef enum logic [1:0] {
    CLEAN         = 2'b00,
    CORRECTED     = 2'b01,
    UNCORRECTABLE = 2'b10
  } err_class_t;

  function automatic int parity_bits(input int dw);
    int r;
    r = 0;
    for (int i = 1; i < 31; i++)
      if (r == 0 && (1 << i) >= dw + i + 1) r = i;
    return r;
  endfunction

  function automatic int code_width(input int dw);
    return dw + parity_bits(dw) + 1;
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword position of data bit j (non power-of-two slots, ascending).
  function automatic int data_pos(input int j);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int pos = 1; pos < 1024; pos++) begin
      if (!is_pow2(pos)) begin
        if (cnt == j && res == 0) res = pos;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_stream.sv
// Minimal AXI-stream bundle with valid/ready handshake.
// Same width is used on both sides of the decoder.
interface axi_stream #(
  parameter int DATA_W = 39,
  parameter int DEST_W = 4,
  parameter int USER_W = 2
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [DEST_W-1:0] dest;
  logic [USER_W-1:0] user;
  logic              tlast;

  modport master (
    output valid, data, dest, user, tlast,
    input  ready
  );

  modport slave (
    input  valid, data, dest, user, tlast,
    output ready
  );
endinterface

// File: rtl/secded_syndrome_stage.sv
// Stage 1: syndrome and overall parity of the incoming codeword,
// registered together with the beat sideband.
module secded_syndrome_stage
  import secded_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_W     = 4,
  localparam int PB        = parity_bits(DATA_WIDTH),
  localparam int CW        = code_width(DATA_WIDTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [CW-1:0]     cw_i,
  input  logic [DEST_W-1:0] dest_i,
  input  logic              tlast_i,
  input  logic              cen_i,
  output logic              valid_o,
  output logic [CW-1:0]     cw_o,
  output logic [PB-1:0]     syn_o,
  output logic              par_o,
  output logic [DEST_W-1:0] dest_o,
  output logic              tlast_o,
  output logic              cen_o
);

  logic              valid_q;
  logic [CW-1:0]     cw_q;
  logic [PB-1:0]     syn_q, syn_d;
  logic              par_q, par_d;
  logic [DEST_W-1:0] dest_q;
  logic              tlast_q;
  logic              cen_q;

  always_comb begin
    syn_d = '0;
    for (int i = 1; i < CW; i++)
      for (int k = 0; k < PB; k++)
        if (((i >> k) & 1) == 1) syn_d[k] = syn_d[k] ^ cw_i[i];
    par_d = ^cw_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      cw_q    <= '0;
      syn_q   <= '0;
      par_q   <= 1'b0;
      dest_q  <= '0;
      tlast_q <= 1'b0;
      cen_q   <= 1'b0;
    end else if (load_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        cw_q    <= cw_i;
        syn_q   <= syn_d;
        par_q   <= par_d;
        dest_q  <= dest_i;
        tlast_q <= tlast_i;
        cen_q   <= cen_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign cw_o    = cw_q;
  assign syn_o   = syn_q;
  assign par_o   = par_q;
  assign dest_o  = dest_q;
  assign tlast_o = tlast_q;
  assign cen_o   = cen_q;

endmodule

// File: rtl/secded_stream_decoder.sv
// Two-stage SECDED stream decoder: syndrome, then correct/extract,
// with per-class saturating error counters.
module secded_stream_decoder
  import secded_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int COUNTER_WIDTH = 16,
  parameter int DEST_W        = 4,
  localparam int PB           = parity_bits(DATA_WIDTH),
  localparam int CW           = code_width(DATA_WIDTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  axi_stream.slave                 data_in,
  axi_stream.master                data_out,
  input  logic                     correct_en,
  input  logic                     clear_counters,
  output logic [COUNTER_WIDTH-1:0] corrected_count,
  output logic [COUNTER_WIDTH-1:0] uncorrectable_count
);

  logic              s1_valid, s1_par, s1_tlast, s1_cen;
  logic [CW-1:0]     s1_cw;
  logic [PB-1:0]     s1_syn;
  logic [DEST_W-1:0] s1_dest;
  logic              s1_load, s1_leaving, s2_load, out_hs;

  logic                  out_valid_q, out_tlast_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  err_class_t            out_user_q;
  logic [DEST_W-1:0]     out_dest_q;

  err_class_t            cls_d;
  logic [CW-1:0]         fixed_cw;
  logic [DATA_WIDTH-1:0] word_d;

  logic [COUNTER_WIDTH-1:0] corr_q, unc_q;
  logic                     unused_bits;

  assign s2_load    = !out_valid_q || data_out.ready;
  assign s1_leaving = s1_valid && s2_load;
  assign s1_load    = !s1_valid || s1_leaving;
  assign out_hs     = out_valid_q && data_out.ready;

  assign data_in.ready = reset && s1_load;

  secded_syndrome_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEST_W     (DEST_W)
  ) u_syn (
    .clk_i   (clock),
    .rst_ni  (reset),
    .load_i  (s1_load),
    .valid_i (data_in.valid),
    .cw_i    (data_in.data),
    .dest_i  (data_in.dest),
    .tlast_i (data_in.tlast),
    .cen_i   (correct_en),
    .valid_o (s1_valid),
    .cw_o    (s1_cw),
    .syn_o   (s1_syn),
    .par_o   (s1_par),
    .dest_o  (s1_dest),
    .tlast_o (s1_tlast),
    .cen_o   (s1_cen)
  );

  // Odd parity with a syndrome outside the code is a multi-bit error.
  always_comb begin
    cls_d    = CLEAN;
    fixed_cw = s1_cw;
    if (s1_syn == '0) begin
      if (s1_par) cls_d = CORRECTED;
    end else if (!s1_par || s1_syn > PB'(CW - 1)) begin
      cls_d = UNCORRECTABLE;
    end else begin
      cls_d = CORRECTED;
      if (s1_cen) fixed_cw = s1_cw ^ (CW'(1) << s1_syn);
    end
  end

  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_ext
    localparam int P = data_pos(j);
    assign word_d[j] = fixed_cw[P];
  end

  assign unused_bits = ^{data_in.user, fixed_cw};

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_user_q  <= CLEAN;
      out_dest_q  <= '0;
      out_tlast_q <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_data_q  <= word_d;
        out_user_q  <= cls_d;
        out_dest_q  <= s1_dest;
        out_tlast_q <= s1_tlast;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || clear_counters) begin
      corr_q <= '0;
      unc_q  <= '0;
    end else if (out_hs) begin
      if (out_user_q == CORRECTED && !(&corr_q))
        corr_q <= corr_q + 1'b1;
      if (out_user_q == UNCORRECTABLE && !(&unc_q))
        unc_q <= unc_q + 1'b1;
    end
  end

  assign data_out.valid = out_valid_q;
  assign data_out.data  = {{(CW - DATA_WIDTH){1'b0}}, out_data_q};
  assign data_out.user  = out_user_q;
  assign data_out.dest  = out_dest_q;
  assign data_out.tlast = out_tlast_q;

  assign corrected_count     = corr_q;
  assign uncorrectable_count = unc_q;

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Directed bench for the SECDED stream decoder (32-bit data,
// 4-bit counters so saturation is reachable).
module tb_secded_stream_decoder;

  localparam int CW = 39;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] cc, uc;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  axi_stream #(.DATA_W(CW), .DEST_W(4), .USER_W(2)) in_if ();
  axi_stream #(.DATA_W(CW), .DEST_W(4), .USER_W(2)) out_if ();

  secded_stream_decoder #(
    .DATA_WIDTH    (32),
    .COUNTER_WIDTH (4),
    .DEST_W        (4)
  ) dut (
    .clock               (clk),
    .reset               (rst_n),
    .data_in             (in_if),
    .data_out            (out_if),
    .correct_en          (cen),
    .clear_counters      (clr),
    .corrected_count     (cc),
    .uncorrectable_count (uc)
  );

  function automatic logic [CW-1:0] enc(input logic [31:0] d);
    logic [CW-1:0] c;
    logic          x;
    int            j;
    c = '0;
    j = 0;
    for (int pos = 1; pos < CW; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[j];
        j++;
      end
    for (int k = 0; k < 6; k++) begin
      x = 1'b0;
      for (int pos = 1; pos < CW; pos++)
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) x = x ^ c[pos];
      c[1 << k] = x;
    end
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [CW-1:0] bit_at(input int p);
    logic [CW-1:0] m;
    m = '0;
    m[p] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [CW-1:0] cw, input logic ce,
                      input logic [31:0] ed, input logic [1:0] eu,
                      input logic clr_hs, input string tag);
    @(negedge clk);
    in_if.valid = 1'b1;
    in_if.data  = cw;
    in_if.dest  = 4'h3;
    in_if.tlast = 1'b1;
    cen = ce;
    out_if.ready = 1'b1;
    #1 chk({tag, "/in_ready"}, in_if.ready, 1);
    @(negedge clk);
    in_if.valid = 1'b0;
    cen = ~ce;
    chk({tag, "/valid_c1"}, out_if.valid, 0);
    @(negedge clk);
    chk({tag, "/valid_c2"}, out_if.valid, 1);
    chk({tag, "/data"}, out_if.data, {7'b0, ed});
    chk({tag, "/user"}, out_if.user, eu);
    chk({tag, "/dest"}, out_if.dest, 4'h3);
    chk({tag, "/tlast"}, out_if.tlast, 1);
    if (clr_hs) clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk({tag, "/valid_c3"}, out_if.valid, 0);
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    int i;
    int nout;
    logic [31:0] pl;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.dest   = '0;
    in_if.user   = 2'b11;
    in_if.tlast  = 1'b0;
    out_if.ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst/in_ready", in_if.ready, 0);
    chk("rst/out_valid", out_if.valid, 0);
    chk("rst/out_data", out_if.data, 0);
    chk("rst/out_user", out_if.user, 0);
    chk("rst/cc", cc, 0);
    chk("rst/uc", uc, 0);
    rst_n = 1'b1;
    #1 chk("rel/in_ready", in_if.ready, 1);

    beat(enc(DB), 1'b1, DB, 2'b00, 1'b0, "clean");
    chk("clean/cc", cc, 0);
    chk("clean/uc", uc, 0);
    beat(enc(DB) ^ bit_at(5), 1'b1, DB, 2'b01, 1'b0, "p5_fix");
    chk("p5_fix/cc", cc, 1);
    beat(enc(DB) ^ bit_at(5), 1'b0, 32'hDEADBEED, 2'b01, 1'b0, "p5_det");
    chk("p5_det/cc", cc, 2);
    beat(enc(DB) ^ bit_at(3) ^ bit_at(10), 1'b1, 32'hDEADBECE, 2'b10,
         1'b0, "dbl");
    chk("dbl/uc", uc, 1);
    beat(enc(DB) ^ bit_at(0), 1'b1, DB, 2'b01, 1'b0, "p0");
    chk("p0/cc", cc, 3);
    beat(enc(DB) ^ bit_at(1) ^ bit_at(8) ^ bit_at(32), 1'b1, DB, 2'b10,
         1'b0, "oob");
    chk("oob/uc", uc, 2);
    beat(enc(32'h12345678) ^ bit_at(38), 1'b1, 32'h12345678, 2'b01,
         1'b0, "p38");
    beat(enc(32'h0) , 1'b1, 32'h0, 2'b00, 1'b0, "zero");
    chk("p38/cc", cc, 4);

    i = 0;
    nout = 0;
    for (int c = 0; c < 60 && nout < 8; c++) begin
      @(negedge clk);
      out_if.ready = !(c >= 3 && c <= 6);
      in_if.valid  = (i < 8);
      in_if.data   = enc(32'hC0DE0000 + 32'(i) * 32'h0101);
      in_if.dest   = 4'(i);
      in_if.tlast  = (i == 7);
      #1;
      if (c == 3) chk("strm/in_ready_drop", in_if.ready, 0);
      if (c == 6) begin
        chk("strm/hold_valid", out_if.valid, 1);
        chk("strm/hold_data", out_if.data, {7'b0, 32'hC0DE0101});
      end
      if (in_if.valid && in_if.ready) i++;
      if (out_if.valid && out_if.ready) begin
        pl = 32'hC0DE0000 + 32'(nout) * 32'h0101;
        chk("strm/data", out_if.data, {7'b0, pl});
        chk("strm/dest", out_if.dest, 4'(nout));
        chk("strm/tlast", out_if.tlast, (nout == 7));
        nout++;
      end
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    chk("strm/out_count", nout, 8);
    chk("strm/in_count", i, 8);
    @(negedge clk);
    chk("strm/cc", cc, 4);
    chk("strm/uc", uc, 2);

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_if.valid = 1'b1;
      in_if.data  = enc(32'h1000 + 32'(k)) ^ bit_at(3 + k);
      cen = 1'b1;
    end
    @(negedge clk);
    in_if.valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat/cc", cc, 15);
    chk("sat/out_valid", out_if.valid, 0);

    beat(enc(DB) ^ bit_at(20), 1'b1, DB, 2'b01, 1'b1, "clr");
    chk("clr/cc", cc, 0);
    chk("clr/uc", uc, 0);

    beat(enc(DB) ^ bit_at(7), 1'b1, DB, 2'b01, 1'b0, "pre");
    chk("pre/cc", cc, 1);
    @(negedge clk);
    in_if.valid = 1'b1;
    in_if.data  = enc(32'h11111111) ^ bit_at(9);
    @(negedge clk);
    in_if.data  = enc(32'h22222222) ^ bit_at(9);
    @(negedge clk);
    in_if.valid = 1'b0;
    chk("flight/out_valid", out_if.valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst/out_valid", out_if.valid, 0);
    chk("mrst/cc", cc, 0);
    chk("mrst/in_ready", in_if.ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst/drained", out_if.valid, 0);
    beat(enc(32'hCAFEF00D), 1'b1, 32'hCAFEF00D, 2'b00, 1'b0, "post");
    chk("post/cc", cc, 0);
    chk("post/uc", uc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
